adau_spi_burst_master: RTL and testbench

//  Parametrised SPI control-port master for the ADAU1761 codec, the successor to the single-register

---
 rtl/adau_spi_burst_master_if.sv | 31 +++
 rtl/adau_spi_burst_master.sv | 214 +++++++++++++++++++++
 tb/tb_adau_spi_burst_master.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adau_spi_burst_master_if.sv
// Request/response bus of the ADAU1761 SPI burst master.
// A request transfers on any clk edge where req_valid && req_ready are both high; the master holds its
// request fields stable while req_valid is high, and rsp_valid is an unconditional one-cycle pulse.
interface adau_spi_burst_master_if #(
  parameter int ADDR_W    = 16,
  parameter int MAX_BYTES = 4
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_rw;
  logic [ADDR_W-1:0]      req_addr;
  logic [LEN_W-1:0]       req_len;
  logic [8*MAX_BYTES-1:0] req_wdata;
  logic                   rsp_valid;
  logic [8*MAX_BYTES-1:0] rsp_rdata;
  logic                   busy;
  logic                   init_done;
  logic [2:0]             state_dbg;

  modport master (
    output req_valid, req_rw, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, init_done, state_dbg
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy, init_done, state_dbg
  );
endinterface

// File: rtl/adau_spi_burst_master.sv
// SPI control-port master for the ADAU1761: SPI-mode entry frames after reset, then
// single/burst register reads and writes with a divided SCLK (mode 0).
module adau_spi_burst_master #(
  parameter int         CLK_DIV     = 4,
  parameter int         ADDR_W      = 16,
  parameter int         MAX_BYTES   = 4,
  parameter int         INIT_WRITES = 3,
  parameter logic [6:0] CHIP_ADDR   = 7'h00
) (
  input  logic                     clk,
  input  logic                     resetn,
  adau_spi_burst_master_if.slave   bus,
  output logic                     sclk,
  output logic                     cs_n,
  output logic                     mosi,
  input  logic                     miso
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam int DW    = 8 * MAX_BYTES;
  localparam int HDR   = 8 + ADDR_W;
  localparam int FW    = HDR + DW;
  localparam int BW    = $clog2(FW + 1);
  localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW    = $clog2(INIT_WRITES + 2);
  localparam int JW    = $clog2(DW);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_SETUP = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic [FW-1:0]   sh_q, sh_d;
  logic [DW-1:0]   rx_q, rx_d;
  logic            rw_q, rw_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic            sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
  logic            req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            init_done_q, init_done_d;
  logic            tick;
  logic [BW-1:0]   last_bit, data_idx;

  // Frame is left-aligned: chip/rw byte, address, then data byte 0 first, each MSB first.
  function automatic logic [FW-1:0] build_frame(input logic rw, input logic [ADDR_W-1:0] addr,
                                                input logic [DW-1:0] wdata);
    logic [FW-1:0] f;
    f = '0;
    f[FW-1 -: 8]      = {CHIP_ADDR, rw};
    f[FW-9 -: ADDR_W] = addr;
    for (int k = 0; k < MAX_BYTES; k++) f[DW-1-8*k -: 8] = wdata[8*k +: 8];
    return f;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)                      return LEN_W'(1);
    else if (l > LEN_W'(MAX_BYTES))   return LEN_W'(MAX_BYTES);
    else                              return l;
  endfunction

  assign tick     = (cnt_q == CW'(CLK_DIV - 1));
  assign last_bit = BW'(HDR - 1) + (BW'(len_q) << 3);
  assign data_idx = bit_cnt_q - BW'(HDR);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    init_cnt_d  = init_cnt_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    rw_d        = rw_q;
    len_d       = len_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    init_done_d = init_done_q;
    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q == IW'(INIT_WRITES)) begin
          init_done_d = 1'b1;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          sh_d    = build_frame(1'b0, ADDR_W'(16'h4000), '0);
          rw_d    = 1'b0;
          len_d   = LEN_W'(1);
          cs_n_d  = 1'b0;
          mosi_d  = sh_d[FW-1];
          state_d = S_SETUP;
        end
      end
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          rw_d        = bus.req_rw;
          len_d       = clamp_len(bus.req_len);
          sh_d        = build_frame(bus.req_rw, bus.req_addr, bus.req_wdata);
          rx_d        = '0;
          req_ready_d = 1'b0;
          cs_n_d      = 1'b0;
          mosi_d      = sh_d[FW-1];
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            // Data bit j of the burst lands in byte j/8, bit 7-j%8, which is simply j^7.
            if (bit_cnt_q >= BW'(HDR)) rx_d[JW'(data_idx) ^ JW'(7)] = miso;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == last_bit) begin
              state_d = S_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
              sh_d      = sh_q << 1;
              mosi_d    = sh_q[FW-2];
            end
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (bit_cnt_q[0]) begin
            if (!init_done_q) begin
              init_cnt_d = init_cnt_q + IW'(1);
              state_d    = S_INIT;
            end else begin
              rsp_valid_d = 1'b1;
              rsp_rdata_d = rw_q ? rx_q : '0;
              req_ready_d = 1'b1;
              state_d     = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_INIT;
    endcase
    // The divider restarts on every state entry and idles at zero outside frames.
    if (tick || state_d != state_q || state_q == S_IDLE || state_q == S_INIT) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      init_cnt_q  <= '0;
      sh_q        <= '0;
      rx_q        <= '0;
      rw_q        <= 1'b0;
      len_q       <= LEN_W'(1);
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      init_cnt_q  <= init_cnt_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      rw_q        <= rw_d;
      len_q       <= len_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      init_done_q <= init_done_d;
    end
  end

  assign sclk          = sclk_q;
  assign cs_n          = cs_n_q;
  assign mosi          = mosi_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.init_done = init_done_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_adau_spi_burst_master.sv
// Bench for adau_spi_burst_master: directed requests, SPI slave model on the pins,
// expected-response queue drained by a monitor on rsp_valid.
`timescale 1ns/1ps
module tb_adau_spi_burst_master;
  localparam int CLK_DIV = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sclk, cs_n, mosi;
  logic miso = 1'b0;

  adau_spi_burst_master_if #(.ADDR_W(16), .MAX_BYTES(4)) bus ();

  adau_spi_burst_master #(
    .CLK_DIV(CLK_DIV), .ADDR_W(16), .MAX_BYTES(4), .INIT_WRITES(3), .CHIP_ADDR(7'h00)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event required none (t=%0t)", name, $time);
  endtask

  // ---------------- SPI slave model ----------------
  typedef struct packed {
    logic [31:0] n;
    logic [63:0] bits;
  } frame_t;
  frame_t      log_q[$];
  int          fr_sclk = 0;
  logic [63:0] fr_bits = '0;
  int          frames = 0;
  int          last_sclk = 0;
  logic [63:0] last_bits = '0;
  logic [31:0] miso_data = '0;

  function automatic logic miso_bit(input int i);
    int j;
    if (i < 24) return 1'b0;
    j = i - 24;
    if (j >= 32) return 1'b0;
    return miso_data[j ^ 7];
  endfunction

  always @(posedge sclk) if (cs_n === 1'b0) begin
    fr_bits <= {fr_bits[62:0], mosi};
    fr_sclk <= fr_sclk + 1;
  end

  always @(negedge cs_n or negedge sclk) if (cs_n === 1'b0) miso <= miso_bit(fr_sclk);

  always @(negedge cs_n) frames <= frames + 1;

  always @(posedge cs_n) begin
    last_sclk <= fr_sclk;
    last_bits <= fr_bits;
    log_q.push_back({32'(fr_sclk), fr_bits});
    fr_sclk <= 0;
    fr_bits <= '0;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] nsclk;
    logic [23:0] hdr;
    logic [31:0] wbits;
    logic [31:0] wmask;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;
  exp_t exp_q[$];
  logic prev_rsp = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t        me;
    logic [63:0] hb;
    if (prev_rsp) check("rsp_pulse_width", bus.rsp_valid, 1'b0);
    prev_rsp <= (bus.rsp_valid === 1'b1);
    if (bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        report_fail("unexpected_rsp");
      end else begin
        me = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, me.rdata);
        check("latency", 64'(cyc - int'(me.acc)), me.lat);
        check("sclk_count", last_sclk, me.nsclk);
        hb = last_bits >> (me.nsclk - 24);
        check("frame_header", hb[23:0], me.hdr);
        if (me.wmask != 0) check("wdata_stream", last_bits[31:0] & me.wmask, me.wbits);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic rw, input logic [15:0] addr, input logic [2:0] len,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input int exp_sclk, input int exp_lat,
                      input logic [31:0] exp_wbits, input logic [31:0] exp_wmask,
                      input bit push_exp);
    exp_t e;
    int   guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = wdata;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      report_fail("req_ready_timeout");
    end else if (push_exp) begin
      e.rdata = exp_rdata;
      e.nsclk = 32'(exp_sclk);
      e.hdr   = {7'h00, rw, addr};
      e.wbits = exp_wbits;
      e.wmask = exp_wmask;
      e.lat   = 32'(exp_lat);
      e.acc   = 32'(cyc);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1'b1);
    check("ready_low_after_accept", bus.req_ready, 1'b0);
  endtask

  task automatic wait_drained();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) report_fail("rsp_timeout");
    @(negedge clk);
  endtask

  task automatic wait_init();
    int guard;
    guard = 0;
    while (bus.init_done !== 1'b1 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) report_fail("init_done_timeout");
  endtask

  task automatic check_init_frames(input int f0);
    frame_t fr;
    check("init_frame_count", frames - f0, 3);
    check("init_log_size", log_q.size(), 3);
    while (log_q.size() != 0) begin
      fr = log_q.pop_front();
      check("init_frame_sclk", fr.n, 32);
      check("init_frame_bits", fr.bits[31:0], 32'h0040_0000);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0;
    int guard;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;

    // T1: reset values and init frames
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_init_done", bus.init_done, 1'b0);
    check("rst_busy", bus.busy, 1'b1);
    log_q.delete();
    f0 = frames;
    resetn = 1'b1;
    wait_init();
    @(negedge clk);
    check_init_frames(f0);
    check("post_init_done", bus.init_done, 1'b1);
    check("post_init_ready", bus.req_ready, 1'b1);
    check("post_init_busy", bus.busy, 1'b0);

    // T2: single write
    send(1'b0, 16'h4000, 3'd1, 32'h0000_0001, 32'h0, 32, 137, 32'h01, 32'hFF, 1'b1);
    wait_drained();

    // T3: single read
    miso_data = 32'h0000_00A5;
    send(1'b1, 16'h4015, 3'd1, 32'h0, 32'h0000_00A5, 32, 137, 32'h0, 32'h0, 1'b1);
    wait_drained();

    // T4: 4-byte burst read, then rdata must hold
    miso_data = 32'h4433_2211;
    send(1'b1, 16'h4002, 3'd4, 32'h0, 32'h4433_2211, 56, 233, 32'h0, 32'h0, 1'b1);
    wait_drained();
    repeat (3) @(negedge clk);
    check("rdata_hold", bus.rsp_rdata, 32'h4433_2211);

    // T5: length clamping (write after read must report zero data)
    send(1'b0, 16'h4010, 3'd0, 32'h0000_00AB, 32'h0, 32, 137, 32'h0000_00AB, 32'hFF, 1'b1);
    wait_drained();
    send(1'b0, 16'h4020, 3'd7, 32'h4433_2211, 32'h0, 56, 233, 32'h1122_3344, 32'hFFFF_FFFF, 1'b1);
    wait_drained();

    // T6: reset in the middle of a write frame
    send(1'b0, 16'h4003, 3'd1, 32'h0000_0055, 32'h0, 32, 137, 32'h55, 32'hFF, 1'b0);
    guard = 0;
    while (fr_sclk < 10 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) report_fail("midframe_wait_timeout");
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    log_q.delete();
    f0 = frames;
    repeat (2) @(negedge clk);
    check("abort_init_done", bus.init_done, 1'b0);
    check("abort_busy", bus.busy, 1'b1);
    resetn = 1'b1;
    wait_init();
    @(negedge clk);
    check_init_frames(f0);

    // Recovery: 2-byte write after the rerun init
    send(1'b0, 16'h4001, 3'd2, 32'h0000_BEEF, 32'h0, 40, 169, 32'h0000_EFBE, 32'h0000_FFFF, 1'b1);
    wait_drained();

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
